// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: fetch/data requesters, fixed-latency access FSM.
// Define MEM_PORT_DEBUG_EN to add a top-priority debug/boot-load requester.
module mem_port_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        Reset,
`ifdef MEM_PORT_DEBUG_EN
  input  logic        DbgReq,
  input  logic        DbgWe,
  input  logic [15:0] DbgAddr,
  input  logic [15:0] DbgWData,
  output logic        DbgDone,
  output logic [15:0] DbgRData,
`endif
  input  logic        IfReq,
  input  logic [15:0] IfAddr,
  output logic        IfDone,
  output logic [15:0] IfRData,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [15:0] DAddr,
  input  logic [15:0] DWData,
  output logic        DDone,
  output logic [15:0] DRData,
  output logic [15:0] MemAddr,
  output logic [15:0] MemWData,
  input  logic [15:0] MemRData,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [1:0] G_IF  = 2'd0;
  localparam logic [1:0] G_D   = 2'd1;
`ifdef MEM_PORT_DEBUG_EN
  localparam logic [1:0] G_DBG = 2'd2;
`endif

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [15:0] ifr_q, ifr_d;
  logic [15:0] dr_q, dr_d;
`ifdef MEM_PORT_DEBUG_EN
  logic [15:0] dbr_q, dbr_d;
`endif

  logic        any_req;
  logic [1:0]  sel;

  // last_q=1 means data was granted last, so fetch wins a tie
  always_comb begin
    any_req = IfReq | DReq;
    sel     = G_IF;
`ifdef MEM_PORT_DEBUG_EN
    any_req = any_req | DbgReq;
    if (DbgReq)
      sel = G_DBG;
    else
`endif
    if (IfReq && DReq)
      sel = last_q ? G_IF : G_D;
    else if (DReq)
      sel = G_D;
    else
      sel = G_IF;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    ifr_d   = ifr_q;
    dr_d    = dr_q;
`ifdef MEM_PORT_DEBUG_EN
    dbr_d   = dbr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ACCESS;
          cnt_d   = WS;
          gnt_d   = sel;
          if (sel == G_IF) begin
            addr_d = IfAddr;
            we_d   = 1'b0;
            last_d = 1'b0;
          end else if (sel == G_D) begin
            addr_d  = DAddr;
            wdata_d = DWData;
            we_d    = DWe;
            last_d  = 1'b1;
          end
`ifdef MEM_PORT_DEBUG_EN
          else begin
            addr_d  = DbgAddr;
            wdata_d = DbgWData;
            we_d    = DbgWe;
          end
`endif
        end
      end
      S_ACCESS: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = S_DONE;
          if (!we_q) begin
            if (gnt_q == G_IF)
              ifr_d = MemRData;
            else if (gnt_q == G_D)
              dr_d = MemRData;
`ifdef MEM_PORT_DEBUG_EN
            else
              dbr_d = MemRData;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 16'h0;
      wdata_q <= 16'h0;
      we_q    <= 1'b0;
      gnt_q   <= G_IF;
      last_q  <= 1'b1;
      ifr_q   <= 16'h0;
      dr_q    <= 16'h0;
`ifdef MEM_PORT_DEBUG_EN
      dbr_q   <= 16'h0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      ifr_q   <= ifr_d;
      dr_q    <= dr_d;
`ifdef MEM_PORT_DEBUG_EN
      dbr_q   <= dbr_d;
`endif
    end
  end

  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign MemRead  = (state_q == S_ACCESS) && !we_q;
  assign MemWrite = (state_q == S_ACCESS) && we_q;
  assign Busy     = (state_q != S_IDLE);
  assign IfDone   = (state_q == S_DONE) && (gnt_q == G_IF);
  assign DDone    = (state_q == S_DONE) && (gnt_q == G_D);
  assign IfRData  = ifr_q;
  assign DRData   = dr_q;
`ifdef MEM_PORT_DEBUG_EN
  assign DbgDone  = (state_q == S_DONE) && (gnt_q == G_DBG);
  assign DbgRData = dbr_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (WAIT_STATES 0 and 1) on shared
// stimulus, checked every cycle against a timeline model of each access.
module tb_mem_port_arbiter;

  logic CLK = 1'b0;
  logic rst_n = 1'b1;
  always #5 CLK = ~CLK;

  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = 16'h0;
  logic [15:0] d_wd = 16'h0;
  logic [15:0] mem_rdata = 16'h0;

  logic        if_done [2];
  logic        d_done  [2];
  logic        mrd     [2];
  logic        mwr     [2];
  logic        busy    [2];
  logic [15:0] if_rd   [2];
  logic [15:0] d_rd    [2];
  logic [15:0] maddr   [2];
  logic [15:0] mwd     [2];
`ifdef MEM_PORT_DEBUG_EN
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [15:0] dbg_addr = 16'h0;
  logic [15:0] dbg_wd = 16'h0;
  logic        dbg_done [2];
  logic [15:0] dbg_rd   [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(.WAIT_STATES(g)) u_dut (
      .CLK      (CLK),
      .Reset    (rst_n),
`ifdef MEM_PORT_DEBUG_EN
      .DbgReq   (dbg_req),
      .DbgWe    (dbg_we),
      .DbgAddr  (dbg_addr),
      .DbgWData (dbg_wd),
      .DbgDone  (dbg_done[g]),
      .DbgRData (dbg_rd[g]),
`endif
      .IfReq    (if_req),
      .IfAddr   (if_addr),
      .IfDone   (if_done[g]),
      .IfRData  (if_rd[g]),
      .DReq     (d_req),
      .DWe      (d_we),
      .DAddr    (d_addr),
      .DWData   (d_wd),
      .DDone    (d_done[g]),
      .DRData   (d_rd[g]),
      .MemAddr  (maddr[g]),
      .MemWData (mwd[g]),
      .MemRData (mem_rdata),
      .MemRead  (mrd[g]),
      .MemWrite (mwr[g]),
      .Busy     (busy[g])
    );
  end

  int checks = 0;
  int failures = 0;

  task automatic chk16(string nm, logic [15:0] got, logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic chk1(string nm, logic got, logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask

  task automatic chki(string nm, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Timeline model: an access granted at edge t0 strobes memory for the
  // W+1 cycles after t0, pulses Done in the next, then is idle again.
  int          cyc;
  int          t0     [2];
  bit          act    [2];
  bit          m_we   [2];
  int          m_g    [2];
  bit          m_last [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_wd   [2];
  logic [15:0] m_ifr  [2];
  logic [15:0] m_dr   [2];
  logic [15:0] m_dbr  [2];
  bit          m_dbg;

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      for (int i = 0; i < 2; i++) begin
        act[i] = 0; t0[i] = 0; m_we[i] = 0; m_g[i] = 0; m_last[i] = 1;
        m_addr[i] = 0; m_wd[i] = 0; m_ifr[i] = 0; m_dr[i] = 0; m_dbr[i] = 0;
      end
    end else begin
      cyc++;
      m_dbg = 1'b0;
`ifdef MEM_PORT_DEBUG_EN
      m_dbg = dbg_req;
`endif
      for (int i = 0; i < 2; i++) begin
        if (!act[i]) begin
          if (m_dbg || if_req || d_req) begin
            act[i] = 1;
            t0[i] = cyc;
            if (m_dbg) m_g[i] = 2;
            else if (if_req && d_req) m_g[i] = m_last[i] ? 0 : 1;
            else m_g[i] = if_req ? 0 : 1;
            if (m_g[i] == 0) begin
              m_addr[i] = if_addr; m_we[i] = 0; m_last[i] = 0;
            end else if (m_g[i] == 1) begin
              m_addr[i] = d_addr; m_we[i] = d_we; m_wd[i] = d_wd; m_last[i] = 1;
            end else begin
`ifdef MEM_PORT_DEBUG_EN
              m_addr[i] = dbg_addr; m_we[i] = dbg_we; m_wd[i] = dbg_wd;
`endif
            end
          end
        end else begin
          if (cyc == t0[i] + i + 1 && !m_we[i]) begin
            if (m_g[i] == 0) m_ifr[i] = mem_rdata;
            else if (m_g[i] == 1) m_dr[i] = mem_rdata;
            else m_dbr[i] = mem_rdata;
          end
          if (cyc == t0[i] + i + 2) act[i] = 0;
        end
      end
    end
  end

  bit e_acc, e_dn;
  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      e_acc = act[i] && (cyc <= t0[i] + i);
      e_dn  = act[i] && (cyc == t0[i] + i + 1);
      chk1($sformatf("u%0d.Busy", i), busy[i], act[i]);
      chk1($sformatf("u%0d.MemRead", i), mrd[i], e_acc && !m_we[i]);
      chk1($sformatf("u%0d.MemWrite", i), mwr[i], e_acc && m_we[i]);
      chk16($sformatf("u%0d.MemAddr", i), maddr[i], m_addr[i]);
      if (e_acc && m_we[i])
        chk16($sformatf("u%0d.MemWData", i), mwd[i], m_wd[i]);
      chk1($sformatf("u%0d.IfDone", i), if_done[i], e_dn && m_g[i] == 0);
      chk1($sformatf("u%0d.DDone", i), d_done[i], e_dn && m_g[i] == 1);
      chk16($sformatf("u%0d.IfRData", i), if_rd[i], m_ifr[i]);
      chk16($sformatf("u%0d.DRData", i), d_rd[i], m_dr[i]);
`ifdef MEM_PORT_DEBUG_EN
      chk1($sformatf("u%0d.DbgDone", i), dbg_done[i], e_dn && m_g[i] == 2);
      chk16($sformatf("u%0d.DbgRData", i), dbg_rd[i], m_dbr[i]);
`endif
    end
  end

  int          rd_cnt  [2];
  int          wr_cnt  [2];
  int          ifd_cnt [2];
  int          dd_cnt  [2];
  int          ifd_idx [2];
  int          overlap [2];
  logic [15:0] s_addr  [2];
  logic [15:0] s_wd    [2];
  int          ord1 [$];

  task automatic observe(int n);
    for (int i = 0; i < 2; i++) begin
      rd_cnt[i] = 0; wr_cnt[i] = 0; ifd_cnt[i] = 0; dd_cnt[i] = 0;
      ifd_idx[i] = -1; overlap[i] = 0; s_addr[i] = 16'hFFFF; s_wd[i] = 16'hFFFF;
    end
    ord1.delete();
    for (int k = 1; k <= n; k++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        if (mrd[i]) rd_cnt[i]++;
        if (mwr[i]) begin wr_cnt[i]++; s_wd[i] = mwd[i]; end
        if (mrd[i] || mwr[i]) s_addr[i] = maddr[i];
        if (if_done[i]) begin
          ifd_cnt[i]++;
          if (ifd_idx[i] < 0) ifd_idx[i] = k;
        end
        if (d_done[i]) dd_cnt[i]++;
        if (if_done[i] && d_done[i]) overlap[i]++;
      end
      if (if_done[1]) ord1.push_back(0);
      if (d_done[1]) ord1.push_back(1);
`ifdef MEM_PORT_DEBUG_EN
      if (dbg_done[1]) ord1.push_back(2);
`endif
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #3;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk1("reset.Busy", busy[i], 1'b0);
      chk1("reset.MemRead", mrd[i], 1'b0);
      chk16("reset.MemAddr", maddr[i], 16'h0);
      chk16("reset.IfRData", if_rd[i], 16'h0);
    end
    step();
    rst_n = 1'b1;
    step();

    // fetch read
    if_req = 1; if_addr = 16'h0010; mem_rdata = 16'hA5C3;
    step();
    if_req = 0;
    observe(8);
    chki("fetch.u1.reads", rd_cnt[1], 2);
    chki("fetch.u1.done_at", ifd_idx[1], 3);
    chk16("fetch.u1.addr", s_addr[1], 16'h0010);
    chk16("fetch.u1.rdata", if_rd[1], 16'hA5C3);
    chki("fetch.u0.reads", rd_cnt[0], 1);
    chki("fetch.u0.done_at", ifd_idx[0], 2);

    // data write
    step();
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wd = 16'h1234;
    step();
    d_req = 0; d_wd = 16'hFFFF;
    observe(8);
    chki("write.u0.writes", wr_cnt[0], 1);
    chki("write.u1.writes", wr_cnt[1], 2);
    chk16("write.u0.addr", s_addr[0], 16'h0200);
    chk16("write.u0.wdata", s_wd[0], 16'h1234);
    chki("write.u0.ddone", dd_cnt[0], 1);
    chk16("write.u0.drdata", d_rd[0], 16'h0000);

    // simultaneous requests from reset release
    step();
    rst_n = 0;
    step();
    d_we = 0; if_addr = 16'h0030; d_addr = 16'h0040; mem_rdata = 16'h5A5A;
    if_req = 1; d_req = 1;
    rst_n = 1;
    observe(20);
    if_req = 0; d_req = 0;
    chki("alt.count", (ord1.size() >= 4) ? 1 : 0, 1);
    if (ord1.size() >= 4) begin
      chki("alt.g0", ord1[0], 0);
      chki("alt.g1", ord1[1], 1);
      chki("alt.g2", ord1[2], 0);
      chki("alt.g3", ord1[3], 1);
    end
    chki("alt.u0.overlap", overlap[0], 0);
    chki("alt.u1.overlap", overlap[1], 0);
    chk16("alt.u1.ifr", if_rd[1], 16'h5A5A);
    chk16("alt.u1.dr", d_rd[1], 16'h5A5A);
    observe(6);

    // reset mid-access
    step();
    if_req = 1; if_addr = 16'h0055;
    step();
    if_req = 0;
    chk1("rstmid.pre.read", mrd[1], 1'b1);
    rst_n = 0;
    #1;
    chk1("rstmid.u1.read", mrd[1], 1'b0);
    chk1("rstmid.u0.read", mrd[0], 1'b0);
    chk1("rstmid.u1.busy", busy[1], 1'b0);
    step();
    rst_n = 1;
    observe(6);
    chki("rstmid.u1.ifdone", ifd_cnt[1] + dd_cnt[1], 0);
    chki("rstmid.u0.ifdone", ifd_cnt[0] + dd_cnt[0], 0);

    // request dropped after grant, inputs changed mid-access
    step();
    d_req = 1; d_we = 0; d_addr = 16'h0077; mem_rdata = 16'hBEEF;
    step();
    d_req = 0; d_addr = 16'h0099;
    observe(8);
    chki("drop.u0.ddone", dd_cnt[0], 1);
    chki("drop.u1.ddone", dd_cnt[1], 1);
    chk16("drop.u1.addr", s_addr[1], 16'h0077);
    chk16("drop.u1.dr", d_rd[1], 16'hBEEF);

`ifdef MEM_PORT_DEBUG_EN
    step();
    rst_n = 0;
    step();
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0AAA;
    if_req = 1; d_req = 1;
    rst_n = 1;
    step();
    dbg_req = 0;
    observe(20);
    if_req = 0; d_req = 0;
    chki("dbg.count", (ord1.size() >= 4) ? 1 : 0, 1);
    if (ord1.size() >= 4) begin
      chki("dbg.g0", ord1[0], 2);
      chki("dbg.g1", ord1[1], 0);
      chki("dbg.g2", ord1[2], 1);
      chki("dbg.g3", ord1[3], 0);
    end
    observe(6);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
